// File: rtl/detector_de_padrao_param_if.sv
// Serial-detector bus: input bit stream with its controls, match pulse and counter outputs.
interface detector_de_padrao_param_if #(
  parameter int CW = 8
);
  logic          en;
  logic          x;
  logic          sobrepor;
  logic          y;
  logic [CW-1:0] contagem;
  logic          saturado;

  modport master (output en, x, sobrepor, input y, contagem, saturado);
  modport slave  (input en, x, sobrepor, output y, contagem, saturado);
endinterface

// File: rtl/detector_de_padrao_param.sv
// Parametrised sliding-window sequence detector with overlap control.
// Optional saturating match counter built when DETECTOR_CONTADOR_EN is defined.
module detector_de_padrao_param #(
  parameter int           N      = 4,
  parameter logic [N-1:0] PADRAO = 4'b1101,
  parameter int           CW     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  detector_de_padrao_param_if.slave bus
);
  localparam int FW = $clog2(N + 1);

  logic [N-1:0]  r_hist;
  logic [FW-1:0] r_cheio;
  logic          r_y;
  logic [N-1:0]  w_janela;
  logic          w_cheio_ok;
  logic          w_match;

  // Window and fill are judged on the incoming bit, so y rises on the final pattern edge.
  assign w_janela   = {r_hist[N-2:0], bus.x};
  assign w_cheio_ok = (32'(r_cheio) + 32'd1) >= 32'(N);
  assign w_match    = bus.en && w_cheio_ok && (w_janela == PADRAO);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hist  <= '0;
      r_cheio <= '0;
      r_y     <= 1'b0;
    end else begin
      r_y <= w_match;
      if (bus.en) begin
        r_hist <= w_janela;
        if (w_match && !bus.sobrepor) begin
          r_cheio <= '0;
        end else if (r_cheio != FW'(N)) begin
          r_cheio <= r_cheio + 1'b1;
        end
      end
    end
  end

  assign bus.y = r_y;

`ifdef DETECTOR_CONTADOR_EN
  logic [CW-1:0] r_contagem;
  logic          w_saturado;

  assign w_saturado = &r_contagem;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_contagem <= '0;
    end else if (w_match && !w_saturado) begin
      r_contagem <= r_contagem + 1'b1;
    end
  end

  assign bus.contagem = r_contagem;
  assign bus.saturado = w_saturado;
`else
  assign bus.contagem = '0;
  assign bus.saturado = 1'b0;
`endif

endmodule

// File: tb/tb_detector_de_padrao_param.sv
// Bench for detector_de_padrao_param: directed vector table, hand sequences and randomized
// traffic against a queue-based window model, on a default and a saturating-counter instance.
module tb_detector_de_padrao_param;
`ifdef DETECTOR_CONTADOR_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst0, rst1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  detector_de_padrao_param_if #(.CW(8)) if0 ();
  detector_de_padrao_param_if #(.CW(2)) if1 ();

  detector_de_padrao_param #(.N(4), .PADRAO(4'b1101), .CW(8)) dut0 (
    .clock(clk), .reset(rst0), .bus(if0.slave));
  detector_de_padrao_param #(.N(4), .PADRAO(4'b0000), .CW(2)) dut1 (
    .clock(clk), .reset(rst1), .bus(if1.slave));

  // Model: bits accepted since the fill last restarted, trimmed to the newest N.
  bit          hq[2][$];
  int unsigned cnt[2];
  bit          ey[2];
  int          pat[2] = '{4'b1101, 4'b0000};
  int unsigned cmax[2] = '{255, 3};

  task automatic model_step(input int d, input bit r, input bit e, input bit xx, input bit s);
    int v;
    if (r) begin
      hq[d].delete();
      cnt[d] = 0;
      ey[d] = 1'b0;
      return;
    end
    ey[d] = 1'b0;
    if (!e) return;
    hq[d].push_back(xx);
    if (hq[d].size() > 4) void'(hq[d].pop_front());
    if (hq[d].size() == 4) begin
      v = 0;
      foreach (hq[d][i]) v = (v << 1) | int'(hq[d][i]);
      if (v == pat[d]) begin
        ey[d] = 1'b1;
        if (cnt[d] < cmax[d]) cnt[d]++;
        if (!s) hq[d].delete();
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r0, input bit e0, input bit x0, input bit s0,
                     input bit r1, input bit e1, input bit x1, input bit s1);
    @(negedge clk);
    rst0 = r0; if0.en = e0; if0.x = x0; if0.sobrepor = s0;
    rst1 = r1; if1.en = e1; if1.x = x1; if1.sobrepor = s1;
    model_step(0, r0, e0, x0, s0);
    model_step(1, r1, e1, x1, s1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_y0"}, int'(if0.y), int'(ey[0]));
    chk({tag, "_cnt0"}, int'(if0.contagem), CNT_ON ? int'(cnt[0]) : 0);
    chk({tag, "_sat0"}, int'(if0.saturado), CNT_ON ? int'(cnt[0] == cmax[0]) : 0);
    chk({tag, "_y1"}, int'(if1.y), int'(ey[1]));
    chk({tag, "_cnt1"}, int'(if1.contagem), CNT_ON ? int'(cnt[1]) : 0);
    chk({tag, "_sat1"}, int'(if1.saturado), CNT_ON ? int'(cnt[1] == cmax[1]) : 0);
  endtask

  typedef struct {
    bit rst, en, x, sob, ey;
    int ec;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit e, input bit xx, input bit s, input bit y, input int c);
    vec_t v;
    v.rst = r; v.en = e; v.x = xx; v.sob = s; v.ey = y; v.ec = c;
    tbl.push_back(v);
  endtask

  initial begin
    bit b1, b2, b3;
    rst0 = 1'b1; rst1 = 1'b1;
    if0.en = 1'b0; if0.x = 1'b0; if0.sobrepor = 1'b0;
    if1.en = 1'b0; if1.x = 1'b0; if1.sobrepor = 1'b0;

    // Basic 1101 detection
    add(1,1,1,1,0,0); add(0,1,1,1,0,0); add(0,1,1,1,0,0); add(0,1,0,1,0,0); add(0,1,1,1,1,1);
    // Overlapping 1101101
    add(1,1,1,1,0,0);
    add(0,1,1,1,0,0); add(0,1,1,1,0,0); add(0,1,0,1,0,0); add(0,1,1,1,1,1);
    add(0,1,1,1,0,1); add(0,1,0,1,0,1); add(0,1,1,1,1,2);
    // Non-overlapping 1101101
    add(1,1,1,0,0,0);
    add(0,1,1,0,0,0); add(0,1,1,0,0,0); add(0,1,0,0,0,0); add(0,1,1,0,1,1);
    add(0,1,1,0,0,1); add(0,1,0,0,0,1); add(0,1,1,0,0,1);
    // Enable gap
    add(1,1,1,1,0,0);
    add(0,1,1,1,0,0); add(0,1,1,1,0,0);
    add(0,0,0,1,0,0); add(0,0,0,1,0,0); add(0,0,0,1,0,0);
    add(0,1,0,1,0,0); add(0,1,1,1,1,1);
    // Reset mid-pattern; reset beats the match the 4th bit would have made
    add(1,1,1,1,0,0);
    add(0,1,1,1,0,0); add(0,1,1,1,0,0); add(0,1,0,1,0,0);
    add(1,1,1,1,0,0);
    add(0,1,1,1,0,0); add(0,1,1,1,0,0); add(0,1,0,1,0,0); add(0,1,1,1,1,1);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].x, tbl[i].sob, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_y", i), int'(if0.y), int'(tbl[i].ey));
      chk($sformatf("vec%0d_cnt", i), int'(if0.contagem), CNT_ON ? tbl[i].ec : 0);
      chk($sformatf("vec%0d_sat", i), int'(if0.saturado), 0);
      $display("vec %0d rst=%0d en=%0d x=%0d sob=%0d -> y=%0d cnt=%0d",
               i, tbl[i].rst, tbl[i].en, tbl[i].x, tbl[i].sob, if0.y, if0.contagem);
    end

    // All-zero pattern: fill gating, then saturation at 3 with CW=2
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("zero_rst_y", int'(if1.y), 0);
    chk("zero_rst_cnt", int'(if1.contagem), 0);
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk($sformatf("zero_bit%0d_y", i), int'(if1.y), (i >= 4) ? 1 : 0);
      chk($sformatf("zero_bit%0d_cnt", i), int'(if1.contagem),
          CNT_ON ? ((i < 4) ? 0 : ((i - 3 > 3) ? 3 : i - 3)) : 0);
      chk($sformatf("zero_bit%0d_sat", i), int'(if1.saturado), (CNT_ON && i >= 6) ? 1 : 0);
      $display("zero bit %0d -> y=%0d cnt=%0d sat=%0d", i, if1.y, if1.contagem, if1.saturado);
    end

    // Randomized traffic on both instances against the model
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_model("rnd_rst");
    for (int i = 0; i < 800; i++) begin
      b1 = ($urandom_range(0, 99) < 85);
      b2 = ($urandom_range(0, 99) < 80);
      b3 = ($urandom_range(0, 99) < 25);
      cyc($urandom_range(0, 149) == 0, b1, 1'($urandom), 1'($urandom),
          $urandom_range(0, 149) == 0, b2, b3, 1'($urandom));
      chk_model($sformatf("rnd%0d", i));
      $display("rnd %0d y0=%0d cnt0=%0d y1=%0d cnt1=%0d sat1=%0d",
               i, if0.y, if0.contagem, if1.y, if1.contagem, if1.saturado);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
